// File: rtl/pipe_stage_reg_if.sv
// Pipeline boundary bus: stall/flush control plus per-lane valid and payload in both directions.
interface pipe_stage_reg_if #(
    parameter int unsigned LANES   = 1,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned STALL_W = 6
);
    logic [STALL_W-1:0]      stall;
    logic                    flush;
    logic [LANES-1:0]        in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        out_valid;
    logic [LANES*DATA_W-1:0] out_data;

    modport master (
        output stall, flush, in_valid, in_data,
        input  out_valid, out_data
    );

    modport slave (
        input  stall, flush, in_valid, in_data,
        output out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register with stall/bubble/hold/flush handling and
// saturating debug statistics (bubble count, hold count, sticky hold timeout).
module pipe_stage_reg #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned LANES      = 1,
    parameter int unsigned STALL_W    = 6,
    parameter int unsigned STAGE      = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HOLD_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus,
    input  logic             clr_stats_i,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] hold_cnt_o,
    output logic             hold_timeout_o
);

    typedef enum logic [1:0] {
        ActRun    = 2'd0,
        ActHold   = 2'd1,
        ActBubble = 2'd2,
        ActFlush  = 2'd3
    } act_e;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] HoldLim = CNT_W'(HOLD_LIMIT);

    act_e                    act_d, act_q;
    logic [LANES-1:0]        valid_d, valid_q;
    logic [LANES*DATA_W-1:0] data_d, data_q;
    logic [CNT_W-1:0]        bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0]        hold_cnt_d, hold_cnt_q;
    logic [CNT_W-1:0]        hold_run_d, hold_run_q;
    logic                    timeout_d, timeout_q;
    logic                    up, dn;

    // Only two bits of the shared stall vector concern this boundary.
    logic unused_stall;
    assign unused_stall = ^bus.stall;

    assign up = bus.stall[STAGE];
    assign dn = bus.stall[STAGE+1];

    always_comb begin
        act_d = ActRun;
        if (bus.flush) begin
            act_d = ActFlush;
        end else if (up && !dn) begin
            act_d = ActBubble;
        end else if (dn) begin
            // up=0/dn=1 is illegal from ctrl and is folded into HOLD.
            act_d = ActHold;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        unique case (act_d)
            ActFlush, ActBubble: begin
                valid_d = '0;
                data_d  = '0;
            end
            ActHold: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
            default: begin
                valid_d = bus.in_valid;
                for (int i = 0; i < int'(LANES); i++) begin
                    data_d[i*DATA_W +: DATA_W] =
                        bus.in_valid[i] ? bus.in_data[i*DATA_W +: DATA_W] : '0;
                end
            end
        endcase
    end

    always_comb begin
        hold_run_d   = '0;
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        timeout_d    = timeout_q;

        if (act_d == ActHold) begin
            hold_run_d = (hold_run_q == HoldLim) ? HoldLim : hold_run_q + 1'b1;
            if (hold_cnt_q != CntMax) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
            // Also re-arms after a clear while the run sits at the limit.
            if (hold_run_d == HoldLim) begin
                timeout_d = 1'b1;
            end
        end

        if (act_d == ActBubble && bubble_cnt_q != CntMax) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end

        if (clr_stats_i) begin
            bubble_cnt_d = '0;
            hold_cnt_d   = '0;
            timeout_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q        <= ActRun;
            valid_q      <= '0;
            data_q       <= '0;
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
            hold_run_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            act_q        <= act_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_run_q   <= hold_run_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign state_o        = act_q;
    assign bubble_cnt_o   = bubble_cnt_q;
    assign hold_cnt_o     = hold_cnt_q;
    assign hold_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the boundary register.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned LANES      = 2;
    localparam int unsigned STALL_W    = 6;
    localparam int unsigned STAGE      = 1;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned HOLD_LIMIT = 4;
    localparam int          SAT        = (1 << CNT_W) - 1;
    localparam int          VW         = LANES + LANES*DATA_W + 2 + 2*CNT_W + 1;

    localparam logic [5:0] ST_RUN    = 6'b000000;
    localparam logic [5:0] ST_BUBBLE = 6'b000010;
    localparam logic [5:0] ST_HOLD   = 6'b000110;

    logic clk = 1'b0;
    logic rst;
    logic clr_stats;
    logic [1:0]       state;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_timeout;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg_if #(.LANES(LANES), .DATA_W(DATA_W), .STALL_W(STALL_W)) bus ();

    pipe_stage_reg #(
        .DATA_W    (DATA_W),
        .LANES     (LANES),
        .STALL_W   (STALL_W),
        .STAGE     (STAGE),
        .CNT_W     (CNT_W),
        .HOLD_LIMIT(HOLD_LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .clr_stats_i   (clr_stats),
        .state_o       (state),
        .bubble_cnt_o  (bubble_cnt),
        .hold_cnt_o    (hold_cnt),
        .hold_timeout_o(hold_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!((bus.stall[STAGE] == 1'b0) && (bus.stall[STAGE+1] == 1'b1)))
        else $error("illegal stall pattern up=0 dn=1 driven");
    end

    // Behavioural model state
    logic [LANES-1:0]  m_valid;
    logic [DATA_W-1:0] m_data [LANES];
    int                m_state, m_bc, m_hc, m_hr;
    bit                m_to;

    function automatic logic [VW-1:0] exp_vec();
        logic [LANES*DATA_W-1:0] d;
        for (int i = 0; i < int'(LANES); i++) d[i*DATA_W +: DATA_W] = m_data[i];
        return {m_valid, d, 2'(m_state), CNT_W'(m_bc), CNT_W'(m_hc), m_to};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.out_valid, bus.out_data, state, bubble_cnt, hold_cnt, hold_timeout};
    endfunction

    function automatic void model_step();
        bit up, dn;
        int act;
        up = bus.stall[STAGE];
        dn = bus.stall[STAGE+1];
        if (rst) begin
            m_valid = '0;
            for (int i = 0; i < int'(LANES); i++) m_data[i] = '0;
            m_state = 0; m_bc = 0; m_hc = 0; m_hr = 0; m_to = 0;
            return;
        end
        if (bus.flush)   act = 3;
        else if (up && !dn) act = 2;
        else if (up || dn)  act = 1;
        else                act = 0;
        m_state = act;
        if (act == 3 || act == 2) begin
            m_valid = '0;
            for (int i = 0; i < int'(LANES); i++) m_data[i] = '0;
        end else if (act == 0) begin
            m_valid = bus.in_valid;
            for (int i = 0; i < int'(LANES); i++)
                m_data[i] = bus.in_valid[i] ? bus.in_data[i*DATA_W +: DATA_W] : '0;
        end
        if (act == 1) begin
            m_hr = (m_hr + 1 > int'(HOLD_LIMIT)) ? int'(HOLD_LIMIT) : m_hr + 1;
            if (m_hc < SAT) m_hc++;
            if (m_hr == int'(HOLD_LIMIT)) m_to = 1;
        end else begin
            m_hr = 0;
        end
        if (act == 2 && m_bc < SAT) m_bc++;
        if (clr_stats) begin
            m_bc = 0; m_hc = 0; m_to = 0;
        end
    endfunction

    task automatic drive(input logic [5:0] st, input logic fl, input logic [1:0] v,
                         input logic [63:0] d0, input logic [63:0] d1, input logic clr);
        bus.stall    = st;
        bus.flush    = fl;
        bus.in_valid = v;
        bus.in_data  = {d1, d0};
        clr_stats    = clr;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it while inputs are still stable.
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(ST_RUN, 1'b0, 2'b11, 64'h1111, 64'h2222, 1'b0);
        step();
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_zero got %h exp 0", obs_vec());
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model got %h exp %h", obs_vec(), exp_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_run();
        drive(ST_RUN, 1'b0, 2'b11, 64'h0000_0400_2402_0001, 64'h0000_0404_2403_0002, 1'b0);
        step();
        checks++;
        if (bus.out_valid !== 2'b11 || state !== 2'd0 ||
            bus.out_data !== {64'h0000_0404_2403_0002, 64'h0000_0400_2402_0001}) begin
            errors++;
            $display("FAIL run_load got v=%b s=%0d d=%h exp v=11 s=0",
                     bus.out_valid, state, bus.out_data);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL run_model got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_zero_gate();
        drive(ST_RUN, 1'b0, 2'b01, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        step();
        checks++;
        if (bus.out_valid !== 2'b01 ||
            bus.out_data !== {64'h0, 64'h0123_4567_89AB_CDEF}) begin
            errors++;
            $display("FAIL zero_gate got v=%b d=%h exp v=01 lane1=0", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_bubble_hold();
        drive(ST_BUBBLE, 1'b0, 2'b11, 64'hAAAA, 64'hBBBB, 1'b0);
        step();
        checks++;
        if (bus.out_valid !== 2'b00 || bus.out_data !== '0 || state !== 2'd2 ||
            bubble_cnt !== 4'd1) begin
            errors++;
            $display("FAIL bubble got v=%b s=%0d bc=%0d exp v=00 s=2 bc=1",
                     bus.out_valid, state, bubble_cnt);
        end
        drive(ST_HOLD, 1'b0, 2'b11, 64'hCCCC, 64'hDDDD, 1'b0);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.out_valid !== 2'b00 || bus.out_data !== '0 || state !== 2'd1 ||
            hold_cnt !== 4'd3 || hold_timeout !== 1'b0) begin
            errors++;
            $display("FAIL hold3 got v=%b s=%0d hc=%0d to=%b exp v=00 s=1 hc=3 to=0",
                     bus.out_valid, state, hold_cnt, hold_timeout);
        end
    endtask

    task automatic test_timeout();
        drive(ST_RUN, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
        step();
        drive(ST_HOLD, 1'b0, 2'b11, 64'h5, 64'h6, 1'b0);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (hold_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got %b exp 0", hold_timeout);
        end
        step();
        checks++;
        if (hold_timeout !== 1'b1 || hold_cnt !== 4'd4) begin
            errors++;
            $display("FAIL timeout_set got to=%b hc=%0d exp to=1 hc=4", hold_timeout, hold_cnt);
        end
        drive(ST_RUN, 1'b0, 2'b00, 64'h0, 64'h0, 1'b0);
        step();
        checks++;
        if (hold_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got %b exp 1", hold_timeout);
        end
        drive(ST_RUN, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
        step();
        checks++;
        if (hold_timeout !== 1'b0 || hold_cnt !== 4'd0) begin
            errors++;
            $display("FAIL timeout_clear got to=%b hc=%0d exp to=0 hc=0", hold_timeout, hold_cnt);
        end
        clr_stats = 1'b0;
    endtask

    task automatic test_flush();
        drive(ST_RUN, 1'b0, 2'b11, 64'h1234, 64'h5678, 1'b0);
        step();
        drive(ST_HOLD, 1'b0, 2'b00, 64'h0, 64'h0, 1'b0);
        step();
        checks++;
        if (bus.out_valid !== 2'b11 || bus.out_data !== {64'h5678, 64'h1234} ||
            hold_cnt !== 4'd1) begin
            errors++;
            $display("FAIL flush_prehold got v=%b hc=%0d exp v=11 hc=1", bus.out_valid, hold_cnt);
        end
        drive(ST_HOLD, 1'b1, 2'b11, 64'h9, 64'h9, 1'b0);
        step();
        checks++;
        if (bus.out_valid !== 2'b00 || bus.out_data !== '0 || state !== 2'd3 ||
            hold_cnt !== 4'd1) begin
            errors++;
            $display("FAIL flush_prio got v=%b s=%0d hc=%0d exp v=00 s=3 hc=1",
                     bus.out_valid, state, hold_cnt);
        end
        drive(ST_RUN, 1'b0, 2'b10, 64'hFFFF, 64'hABCD, 1'b0);
        step();
        checks++;
        if (bus.out_valid !== 2'b10 || bus.out_data !== {64'hABCD, 64'h0} || state !== 2'd0) begin
            errors++;
            $display("FAIL flush_reload got v=%b d=%h s=%0d exp v=10 s=0",
                     bus.out_valid, bus.out_data, state);
        end
    endtask

    task automatic test_saturation_reset();
        drive(ST_BUBBLE, 1'b0, 2'b11, 64'h1, 64'h2, 1'b0);
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bubble_cnt !== 4'd15) begin
            errors++;
            $display("FAIL bubble_sat got %0d exp 15", bubble_cnt);
        end
        drive(ST_RUN, 1'b0, 2'b11, 64'h77, 64'h88, 1'b0);
        step();
        drive(ST_HOLD, 1'b0, 2'b11, 64'h0, 64'h0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_midhold got %h exp 0", obs_vec());
        end
        rst = 1'b0;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_midhold_model got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int  r;
        bit  in_hold = 0;
        int  bad = 0;
        logic [5:0] st;
        for (int n = 0; n < 600; n++) begin
            r  = $urandom_range(0, 99);
            st = 6'($urandom) & 6'b111001;
            if ((in_hold && r < 75) || (!in_hold && r < 25)) begin
                st |= ST_HOLD;
                in_hold = 1;
            end else begin
                in_hold = 0;
                if ($urandom_range(0, 3) == 0) st |= ST_BUBBLE;
            end
            drive(st, ($urandom_range(0, 11) == 0), 2'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 13) == 0));
            rst = ($urandom_range(0, 79) == 0);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_%0d got %h exp %h", n, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(ST_RUN, 1'b0, 2'b00, 64'h0, 64'h0, 1'b0);
        test_reset();
        test_run();
        test_zero_gate();
        test_bubble_hold();
        test_timeout();
        test_flush();
        test_saturation_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
